// File: rtl/target_match_unit_pkg.sv
// Shared types and constants for the target match unit.
// Provides the FSM state enum, mode encodings and default sizes.
package target_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MATCHED
    } state_e;

    localparam logic MODE_EQ = 1'b0;
    localparam logic MODE_GE = 1'b1;

    localparam int DEF_WIDTH    = 13;
    localparam int DEF_CHANNELS = 4;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/target_match_unit_if.sv
// Bus bundle for the target match unit.
// master: value, load_*, arm, disarm out; slave: match/first/busy out.
interface target_match_unit_if
    import target_match_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int CH_W = ch_w(CHANNELS);

    logic [WIDTH-1:0]    value;
    logic                load_en;
    logic [CH_W-1:0]     load_ch;
    logic [WIDTH-1:0]    load_target;
    logic                load_mode;
    logic                arm;
    logic                disarm;
    logic [CHANNELS-1:0] match_level;
    logic [CHANNELS-1:0] match_pulse;
    logic [CHANNELS-1:0] sticky;
    logic                first_valid;
    logic [CH_W-1:0]     first_ch;
    logic                busy;

    modport master (
        output value, load_en, load_ch, load_target, load_mode,
        output arm, disarm,
        input  match_level, match_pulse, sticky,
        input  first_valid, first_ch, busy
    );

    modport slave (
        input  value, load_en, load_ch, load_target, load_mode,
        input  arm, disarm,
        output match_level, match_pulse, sticky,
        output first_valid, first_ch, busy
    );

endinterface

// File: rtl/target_match_unit_cmp.sv
// Single-channel comparator: EQ or GE of value against target.
// Ports: value, target, mode, enable in; hit out (0 when disabled).
module match_cmp
    import target_match_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] target,
    input  logic             mode,
    input  logic             enable,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        if (enable) begin
            hit = (mode == MODE_GE) ? (value >= target)
                                    : (value == target);
        end
    end

endmodule

// File: rtl/target_match_unit.sv
// Multi-channel registered comparator with first-hit capture.
// Ports: clk, rst_n, bus (slave: value/load/arm/disarm in, flags out).
module target_match_unit
    import target_match_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    target_match_unit_if.slave   bus
);

    localparam int CH_W = ch_w(CHANNELS);

    logic [WIDTH-1:0]    tgt_q [CHANNELS];
    logic [CHANNELS-1:0] mode_q;

    state_e              state_q, state_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] sticky_q, sticky_d;
    logic                fv_q, fv_d;
    logic [CH_W-1:0]     fch_q, fch_d;
    logic                busy_q;

    logic [CHANNELS-1:0] raw;
    logic [CH_W-1:0]     low_idx;
    logic                cmp_en;
    logic                clr;

    // arm/disarm cycles restart detection, so their hits are dropped.
    assign clr    = bus.arm | bus.disarm;
    assign cmp_en = (state_q != IDLE) & ~clr;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_cmp
        match_cmp #(.WIDTH(WIDTH)) u_cmp (
            .value  (bus.value),
            .target (tgt_q[g]),
            .mode   (mode_q[g]),
            .enable (cmp_en),
            .hit    (raw[g])
        );
    end

    // Lowest set index wins: scan downward so it is written last.
    always_comb begin
        low_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (raw[i]) low_idx = CH_W'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        level_d  = raw;
        pulse_d  = raw & ~level_q;
        sticky_d = sticky_q | raw;
        fv_d     = fv_q;
        fch_d    = fch_q;
        if (bus.disarm) begin
            state_d = IDLE;
        end else if (bus.arm) begin
            state_d = ARMED;
        end else if (state_q == ARMED && |raw) begin
            state_d = MATCHED;
            fv_d    = 1'b1;
            fch_d   = low_idx;
        end
        if (clr) begin
            level_d  = '0;
            pulse_d  = '0;
            sticky_d = '0;
            fv_d     = 1'b0;
            fch_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            level_q  <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            fv_q     <= 1'b0;
            fch_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            fv_q     <= fv_d;
            fch_q    <= fch_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // Out-of-range channel indices match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) tgt_q[i] <= '0;
            mode_q <= {CHANNELS{MODE_EQ}};
        end else if (bus.load_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(bus.load_ch) == i) begin
                    tgt_q[i]  <= bus.load_target;
                    mode_q[i] <= bus.load_mode;
                end
            end
        end
    end

    assign bus.match_level = level_q;
    assign bus.match_pulse = pulse_q;
    assign bus.sticky      = sticky_q;
    assign bus.first_valid = fv_q;
    assign bus.first_ch    = fch_q;
    assign bus.busy        = busy_q;

endmodule
